// File: rtl/execute_stage_pkg.sv
// Shared decode constants, instruction field helpers and md-unit op encoding
// for the EX stage.
package execute_stage_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned MD_OP_W = 4;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_LW       = 6'b100011;
  localparam logic [5:0] OP_SW       = 6'b101011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // SPECIAL2 function codes
  localparam logic [5:0] FN_MADD  = 6'b000000;
  localparam logic [5:0] FN_MADDU = 6'b000001;
  localparam logic [5:0] FN_MSUB  = 6'b000100;
  localparam logic [5:0] FN_MSUBU = 6'b000101;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE,
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU,
    MD_MADD,
    MD_MADDU,
    MD_MSUB,
    MD_MSUBU,
    MD_MTHI,
    MD_MTLO
  } md_op_e;

  function automatic logic [5:0] inst_opcode(input logic [XLEN-1:0] inst);
    return inst[31:26];
  endfunction

  function automatic logic [5:0] inst_funct(input logic [XLEN-1:0] inst);
    return inst[5:0];
  endfunction

  function automatic logic [15:0] inst_imm(input logic [XLEN-1:0] inst);
    return inst[15:0];
  endfunction

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/execute_stage_md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO. Build with MD_MADD_EN to
// enable madd/maddu/msub/msubu accumulation into {HI,LO}.
module md_unit
  import execute_stage_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        rs,
  input  logic [31:0]        rt,
  input  logic [MD_OP_W-1:0] op,
  input  logic               start,
  output logic               busy,
  output logic [31:0]        HI,
  output logic [31:0]        LO
);

  md_op_e            op_e;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  md_op_e            op_q, op_d;
  logic              accept;

  logic signed [63:0]        prod_s;
  logic [63:0]               prod_u;
  logic signed [XLEN-1:0]    divisor_s, quo_s, rem_s;
  logic [XLEN-1:0]           divisor_u, quo_u, rem_u;
  logic                      b_zero, div_ovf;
  logic [63:0]               res;
  logic                      res_we;

  assign op_e = md_op_e'(op);

  // Result datapath, evaluated from the latched operands at completion.
  assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u  = {32'b0, a_q} * {32'b0, b_q};
  assign b_zero  = (b_q == '0);
  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == '1);

  // Substitute a unit divisor so the divider never sees /0 or MIN/-1;
  // MIN/1 yields the correct wrapped quotient and remainder for MIN/-1.
  assign divisor_s = (b_zero || div_ovf) ? 32'sd1 : $signed(b_q);
  assign divisor_u = b_zero ? 32'd1 : b_q;
  assign quo_s     = $signed(a_q) / divisor_s;
  assign rem_s     = $signed(a_q) % divisor_s;
  assign quo_u     = a_q / divisor_u;
  assign rem_u     = a_q % divisor_u;

  always_comb begin
    res    = {hi_q, lo_q};
    res_we = 1'b1;
    case (op_q)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        res    = {rem_s, quo_s};
        res_we = !b_zero;
      end
      MD_DIVU: begin
        res    = {rem_u, quo_u};
        res_we = !b_zero;
      end
`ifdef MD_MADD_EN
      MD_MADD:  res = {hi_q, lo_q} + prod_s;
      MD_MADDU: res = {hi_q, lo_q} + prod_u;
      MD_MSUB:  res = {hi_q, lo_q} - prod_s;
      MD_MSUBU: res = {hi_q, lo_q} - prod_u;
`endif
      default:  res_we = 1'b0;
    endcase
  end

  // Next-state: mt writes, start latch, countdown and commit.
  always_comb begin
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    accept  = start && (count_q == '0);
    busy    = !reset && (start || (count_q != '0));

    if (op_e == MD_MTHI) hi_d = rs;
    if (op_e == MD_MTLO) lo_d = rs;

    if (accept) begin
      a_d     = rs;
      b_d     = rt;
      op_d    = op_e;
      count_d = md_is_div(op_e) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
      // Completion overrides any mt write landing on the same edge.
      if (count_q == CNT_W'(1) && res_we) begin
        hi_d = res[63:32];
        lo_d = res[31:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= MD_NONE;
    end else begin
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: instruction decode, ALU and the multiply/divide unit.
// Build with MD_MADD_EN to decode SPECIAL2 madd/maddu/msub/msubu.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] Inst_out,
  output logic [31:0] AO_out,
  output logic [31:0] rt_out,
  output logic        busy
);

  logic [5:0]      opcode, funct;
  logic [15:0]     imm;
  logic [XLEN-1:0] imm_sext, imm_zext;
  logic [XLEN-1:0] hi, lo;
  logic [XLEN-1:0] ao_c;
  md_op_e          md_op_c;
  logic            md_req_c;

  assign opcode   = inst_opcode(Inst);
  assign funct    = inst_funct(Inst);
  assign imm      = inst_imm(Inst);
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  // Decode and ALU; unknown encodings give 0 and leave the md unit alone.
  always_comb begin
    ao_c     = '0;
    md_op_c  = MD_NONE;
    md_req_c = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU:  ao_c = rs + rt;
          FN_SUBU:  ao_c = rs - rt;
          FN_AND:   ao_c = rs & rt;
          FN_OR:    ao_c = rs | rt;
          FN_SLT:   ao_c = {31'b0, ($signed(rs) < $signed(rt))};
          FN_SLTU:  ao_c = {31'b0, (rs < rt)};
          FN_MFHI:  ao_c = hi;
          FN_MFLO:  ao_c = lo;
          FN_MTHI:  md_op_c = MD_MTHI;
          FN_MTLO:  md_op_c = MD_MTLO;
          FN_MULT: begin
            md_op_c  = MD_MULT;
            md_req_c = 1'b1;
          end
          FN_MULTU: begin
            md_op_c  = MD_MULTU;
            md_req_c = 1'b1;
          end
          FN_DIV: begin
            md_op_c  = MD_DIV;
            md_req_c = 1'b1;
          end
          FN_DIVU: begin
            md_op_c  = MD_DIVU;
            md_req_c = 1'b1;
          end
          default: ;
        endcase
      end
`ifdef MD_MADD_EN
      OP_SPECIAL2: begin
        case (funct)
          FN_MADD: begin
            md_op_c  = MD_MADD;
            md_req_c = 1'b1;
          end
          FN_MADDU: begin
            md_op_c  = MD_MADDU;
            md_req_c = 1'b1;
          end
          FN_MSUB: begin
            md_op_c  = MD_MSUB;
            md_req_c = 1'b1;
          end
          FN_MSUBU: begin
            md_op_c  = MD_MSUBU;
            md_req_c = 1'b1;
          end
          default: ;
        endcase
      end
`endif
      OP_ADDIU, OP_LW, OP_SW: ao_c = rs + imm_sext;
      OP_ORI:                 ao_c = rs | imm_zext;
      OP_LUI:                 ao_c = {imm, 16'b0};
      default: ;
    endcase
  end

  md_unit #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .rs    (rs),
    .rt    (rt),
    .op    (md_op_c),
    .start (md_req_c),
    .busy  (busy),
    .HI    (hi),
    .LO    (lo)
  );

  assign Inst_out = Inst;
  assign AO_out   = ao_c;
  assign rt_out   = rt;

endmodule
